// File: rtl/tap_event_fifo.sv
`timescale 1ns/1ps
// tap_event_fifo
//   Watches the tapped counter bits and turns every change of the tapped value
//   into an event record {new_value, timestamp}. Events are queued in a small
//   FIFO and handed to a host-side reader over a valid/ready stream. An event
//   that finds the FIFO full (and no pop in the same cycle) is dropped and
//   latches a sticky overflow flag.
//
// Ports
//   clk       clock, all logic on posedge
//   rst_n     synchronous reset, active-low
//   tap_in    tapped counter value (IN_W bits), synchronous to clk
//   en        1 = record changes, 0 = ignore changes (tracking continues)
//   ev_valid  FIFO non-empty, ev_data valid
//   ev_ready  reader accepts the head entry when ev_valid && ev_ready
//   ev_data   head entry {value, ts}
//   level     number of stored entries, 0..DEPTH
//   overflow  sticky dropped-event flag, cleared only by reset
module tap_event_fifo #(
    parameter int IN_W  = 2,
    parameter int TS_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IN_W-1:0]              tap_in,
    input  logic                         en,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output logic [IN_W+TS_W-1:0]         ev_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = IN_W + TS_W;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [TS_W-1:0] r_ts;
    logic [IN_W-1:0] r_prev;
    logic            r_armed;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [LW-1:0]   r_level;
    logic            r_overflow;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr;

    // armed keeps the very first post-reset sample from looking like a change
    assign w_push = r_armed && en && (tap_in != r_prev);
    assign w_full = (r_level == FULL_LVL);
    assign w_pop  = ev_valid && ev_ready;
    // a full FIFO still accepts a write when the head is leaving this cycle
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts       <= '0;
            r_prev     <= '0;
            r_armed    <= 1'b0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_ts    <= r_ts + TS_W'(1);
            r_prev  <= tap_in;
            r_armed <= 1'b1;
            if (w_wr) begin
                r_mem[r_wr] <= {tap_in, r_ts};
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign ev_valid = (r_level != '0);
    assign ev_data  = r_mem[r_rd];
    assign level    = r_level;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_tap_event_fifo.sv
`timescale 1ns/1ps
module tb_tap_event_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] tap_in;
    logic       en;
    logic       ev_valid;
    logic       ev_ready;
    logic [9:0] ev_data;
    logic [2:0] level;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] tsm = 8'd0;   // expected value of the DUT timestamp register

    tap_event_fifo #(.IN_W(2), .TS_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tap_in(tap_in), .en(en),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) tsm = tsm + 8'd1;
        else       tsm = 8'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; ev_ready = 1'b0; tap_in = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tap_in = 2'(i + 1);
            tick();
        end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ev_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++; if (ev_data !== 10'h000) begin errors++; $display("FAIL reset_data got %h exp 000", ev_data); end
        // tap_in=3 differs from reset prev=0 but the first sample must not push
        rst_n = 1'b1;
        tick();
        checks++; if (ev_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL first_sample valid %b level %0d exp 0/0", ev_valid, level); end
    endtask

    task automatic test_single();
        int guard;
        en = 1'b0; tap_in = 2'd0;
        guard = 0;
        while (tsm != 8'd5 && guard < 300) begin tick(); guard++; end
        checks++; if (tsm != 8'd5) begin errors++; $display("FAIL single_align ts %0d exp 5", tsm); end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_en0 valid %b exp 0", ev_valid); end
        en = 1'b1; tap_in = 2'd2;
        tick();
        checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ev_valid); end
        checks++; if (ev_data !== 10'h205) begin errors++; $display("FAIL single_data got %h exp 205", ev_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++; if (ev_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL single_pop valid %b level %0d exp 0/0", ev_valid, level); end
    endtask

    task automatic test_backpressure();
        logic [9:0] exp [3];
        en = 1'b0; tap_in = 2'd0;
        tick();
        en = 1'b1; ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tap_in = 2'(i + 1);
            exp[i] = {2'(i + 1), tsm};
            tick();
        end
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL bp_level got %0d exp 3", level); end
        checks++; if (ev_data !== exp[0]) begin errors++; $display("FAIL bp_head got %h exp %h", ev_data, exp[0]); end
        tick();
        checks++; if (ev_data !== exp[0] || level !== 3'd3) begin errors++; $display("FAIL bp_stable data %h level %0d exp %h/3", ev_data, level, exp[0]); end
        checks++; if (exp[1][7:0] != exp[0][7:0] + 8'd1 || exp[2][7:0] != exp[0][7:0] + 8'd2) begin errors++; $display("FAIL bp_ts_model"); end
        ev_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ev_data !== exp[i]) begin errors++; $display("FAIL bp_order%0d got %h exp %h", i, ev_data, exp[i]); end
            tick();
        end
        ev_ready = 1'b0;
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL bp_empty valid %b exp 0", ev_valid); end
    endtask

    task automatic test_overflow();
        logic [9:0] exp [4];
        logic [1:0] vals [6];
        vals = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        en = 1'b1; ev_ready = 1'b0;   // tap_in is 3 from the previous test
        for (int i = 0; i < 6; i++) begin
            tap_in = vals[i];
            if (i < 4) exp[i] = {vals[i], tsm};
            tick();
            if (i == 3) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
            end
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ev_data !== exp[i]) begin errors++; $display("FAIL ovf_order%0d got %h exp %h", i, ev_data, exp[i]); end
            tick();
        end
        ev_ready = 1'b0;
        checks++; if (level !== 3'd0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky level %0d ovf %b exp 0/1", level, overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [9:0] exp [5];
        // leave one event pending, then reset must discard it
        en = 1'b1; ev_ready = 1'b0; tap_in = 2'd2;
        tick();
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL fpp_pre level %0d exp 1", level); end
        rst_n = 1'b0; tap_in = 2'd0;
        tick(); tick();
        checks++; if (level !== 3'd0 || ev_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_reset level %0d valid %b ovf %b exp 0/0/0", level, ev_valid, overflow); end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tap_in = 2'((i + 1) % 4);
            exp[i] = {2'((i + 1) % 4), tsm};
            tick();
        end
        checks++; if (level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_full level %0d ovf %b exp 4/0", level, overflow); end
        tap_in = 2'd1; ev_ready = 1'b1;
        exp[4] = {2'd1, tsm};
        tick();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_level got %0d exp 4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", overflow); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (ev_data !== exp[i]) begin errors++; $display("FAIL fpp_order%0d got %h exp %h", i, ev_data, exp[i]); end
            tick();
        end
        ev_ready = 1'b0;
        checks++; if (level !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_drain level %0d ovf %b exp 0/0", level, overflow); end
    endtask

    task automatic test_en_wrap();
        int guard;
        en = 1'b0; tap_in = 2'd3;     // change 1->3 while disabled
        tick();
        en = 1'b1;
        tick(); tick();
        checks++; if (ev_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL en_gate valid %b level %0d exp 0/0", ev_valid, level); end
        guard = 0;
        while (tsm != 8'hFF && guard < 300) begin tick(); guard++; end
        checks++; if (tsm != 8'hFF) begin errors++; $display("FAIL wrap_timeout ts %0d", tsm); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL wrap_idle level %0d exp 0", level); end
        tap_in = 2'd2;
        tick();
        tap_in = 2'd0;
        tick();
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL wrap_level got %0d exp 2", level); end
        checks++; if (ev_data !== 10'h2FF) begin errors++; $display("FAIL wrap_ff got %h exp 2ff", ev_data); end
        ev_ready = 1'b1;
        tick();
        checks++; if (ev_data !== 10'h000 || level !== 3'd1) begin errors++; $display("FAIL wrap_00 got %h level %0d exp 000/1", ev_data, level); end
        tick();
        ev_ready = 1'b0;
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty valid %b exp 0", ev_valid); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ev_ready = 1'b0; tap_in = 2'd0;
        #2;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_en_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
